// File: rtl/mux_pipeline_arbiter_pkg.sv
// Shared types and helpers for the pipelined-mux arbiter.
//   arb_state_t : arbiter FSM encoding (idle / settle / output)
//   sel_width   : select width for a given requester count
//   cnt_width   : settle-counter width for a given mux latency
//   rr_next     : first requesting index strictly after ptr, wrapping at n
package mux_pipeline_arbiter_pkg;

    localparam int unsigned RR_MAX_REQ = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUTPUT = 2'd2
    } arb_state_t;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned latency);
        return $clog2(latency + 1) + 1;
    endfunction

    // Scans ptr+1, ptr+2, ... (mod n); ptr itself is tried last, so the
    // previous winner only repeats when it is the sole requester.
    function automatic int unsigned rr_next(input logic [RR_MAX_REQ-1:0] req,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned idx;
        logic        found;
        rr_next = ptr;
        found   = 1'b0;
        for (int unsigned k = 1; k <= RR_MAX_REQ; k++) begin
            if (k <= n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx]) begin
                    rr_next = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/mux_lfmr.sv
// Fixed-latency pipelined multiplexer: out = in[sel] delayed by LATENCY clocks.
//   clk : rising-edge clock (datapath only, no reset)
//   sel : lane select
//   in  : INPUT_COUNT lanes of WIDTH bits, lane i at [i*WIDTH +: WIDTH]
//   out : selected lane after LATENCY register stages (combinational when 0)
module mux_lfmr #(
    parameter  int unsigned WIDTH       = 8,
    parameter  int unsigned INPUT_COUNT = 4,
    parameter  int unsigned LATENCY     = 2,
    parameter  int unsigned TYPE        = 0,
    parameter  int unsigned PRINT       = 0,
    localparam int unsigned SEL_WIDTH   = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1
) (
    input  logic                         clk,
    input  logic [SEL_WIDTH-1:0]         sel,
    input  logic [WIDTH*INPUT_COUNT-1:0] in,
    output logic [WIDTH-1:0]             out
);

    // Only the fixed-latency variant exists; PRINT is a 0/1 enable.
    if (TYPE != 0 || PRINT > 1) begin : g_bad_cfg
        $error("mux_lfmr: unsupported TYPE/PRINT");
    end

    logic [WIDTH-1:0] mux_c;

    always_comb mux_c = in[sel*WIDTH +: WIDTH];

    if (LATENCY == 0) begin : g_comb
        assign out = mux_c;
    end else begin : g_pipe
        logic [WIDTH-1:0] pipe_q [LATENCY];

        // Plain shift register behind the mux; no reset needed on data.
        always_ff @(posedge clk) begin
            pipe_q[0] <= mux_c;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign out = pipe_q[LATENCY-1];
    end

endmodule

// File: rtl/mux_pipeline_arbiter_rr_pick.sv
// Combinational round-robin pick.
//   req         : request vector
//   ptr         : index of the previous winner
//   grant_c     : first requesting index after ptr (wrap-around)
//   any_valid_c : at least one request present
module mux_pipeline_arbiter_rr_pick
    import mux_pipeline_arbiter_pkg::*;
#(
    parameter  int unsigned INPUT_COUNT = 4,
    localparam int unsigned SEL_WIDTH   = sel_width(INPUT_COUNT)
) (
    input  logic [INPUT_COUNT-1:0] req,
    input  logic [SEL_WIDTH-1:0]   ptr,
    output logic [SEL_WIDTH-1:0]   grant_c,
    output logic                   any_valid_c
);

    always_comb begin
        any_valid_c = |req;
        grant_c     = SEL_WIDTH'(rr_next(RR_MAX_REQ'(req), 32'(ptr), INPUT_COUNT));
    end

endmodule

// File: rtl/mux_pipeline_arbiter.sv
// Shares one pipelined mux (mux_lfmr) among INPUT_COUNT valid/ready requesters.
// A round-robin grant drives the registered select, which is held until the
// mux pipeline has flushed; the result is then captured and presented on a
// valid/ready port tagged with the source index.
//   clk, rst  : clock, synchronous active-high reset
//   req_valid : per-requester request
//   req_ready : one-cycle accept pulse to the served requester
//   req_data  : requester i at [i*WIDTH +: WIDTH], routed straight into the mux
//   out_valid / out_ready / out_data / out_sel : result port and source index
module mux_pipeline_arbiter
    import mux_pipeline_arbiter_pkg::*;
#(
    parameter  int unsigned WIDTH       = 8,
    parameter  int unsigned INPUT_COUNT = 4,
    parameter  int unsigned LATENCY     = 2,
    parameter  int unsigned TYPE        = 0,
    parameter  int unsigned PRINT       = 0,
    localparam int unsigned SEL_WIDTH   = sel_width(INPUT_COUNT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INPUT_COUNT-1:0]       req_valid,
    output logic [INPUT_COUNT-1:0]       req_ready,
    input  logic [WIDTH*INPUT_COUNT-1:0] req_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [SEL_WIDTH-1:0]         out_sel
);

    localparam int unsigned CNT_WIDTH = cnt_width(LATENCY);

    if (INPUT_COUNT < 2 || INPUT_COUNT > RR_MAX_REQ) begin : g_bad_count
        $error("mux_pipeline_arbiter: INPUT_COUNT out of range");
    end

    arb_state_t             state_q, state_d;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic [SEL_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [INPUT_COUNT-1:0] req_ready_d;
    logic                   out_valid_d;
    logic [WIDTH-1:0]       out_data_d;
    logic [SEL_WIDTH-1:0]   out_sel_d;
    logic                   arbitrate;
    logic [SEL_WIDTH-1:0]   grant_c;
    logic                   any_valid_c;
    logic [WIDTH-1:0]       mux_out_c;

    mux_pipeline_arbiter_rr_pick #(
        .INPUT_COUNT (INPUT_COUNT)
    ) u_rr_pick (
        .req         (req_valid),
        .ptr         (ptr_q),
        .grant_c     (grant_c),
        .any_valid_c (any_valid_c)
    );

    mux_lfmr #(
        .WIDTH       (WIDTH),
        .INPUT_COUNT (INPUT_COUNT),
        .LATENCY     (LATENCY),
        .TYPE        (TYPE),
        .PRINT       (PRINT)
    ) u_mux (
        .clk (clk),
        .sel (sel_q),
        .in  (req_data),
        .out (mux_out_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state; a dropped request during settle abandons the grant.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_valid_c) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!req_valid[sel_q])  state_d = ST_IDLE;
                else if (cnt_q == '0)   state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (out_ready) state_d = any_valid_c ? ST_SETTLE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the select, counter and registered outputs.
    // Arbitration happens from IDLE and on the output handshake alike.
    always_comb begin
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        req_ready_d = '0;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_sel_d   = out_sel;
        arbitrate   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                arbitrate = 1'b1;
            end
            ST_SETTLE: begin
                if (req_valid[sel_q]) begin
                    if (cnt_q == '0) begin
                        out_data_d         = mux_out_c;
                        out_sel_d          = sel_q;
                        out_valid_d        = 1'b1;
                        req_ready_d[sel_q] = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_WIDTH'(1);
                    end
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    arbitrate   = 1'b1;
                end
            end
            default: ;
        endcase
        if (arbitrate && any_valid_c) begin
            sel_d = grant_c;
            ptr_d = grant_c;
            cnt_d = CNT_WIDTH'(LATENCY);
        end
    end

    // Datapath and output registers. Pointer resets to the last index so
    // requester 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            ptr_q     <= SEL_WIDTH'(INPUT_COUNT - 1);
            cnt_q     <= '0;
            req_ready <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else begin
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            req_ready <= req_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_sel   <= out_sel_d;
        end
    end

endmodule

// File: tb/tb_mux_pipeline_arbiter.sv
// Bench for mux_pipeline_arbiter: directed scenarios on a WIDTH=8 / 4-input /
// LATENCY=2 instance, then randomized traffic on several (LATENCY, INPUT_COUNT)
// configurations checked against a transaction-level reference model.
module tb_mux_pipeline_arbiter;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;
    localparam int unsigned L = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // First requesting index after 'last', wrapping; 'last' only if alone.
    function automatic int rr_model(input logic [31:0] v, input int last, input int n);
        for (int k = 1; k <= n; k++) begin
            int i;
            i = (last + k) % n;
            if (v[i]) return i;
        end
        return last;
    endfunction

    function automatic int unsigned cfg_lat(input int k);
        case (k)
            0:       return 2;
            1:       return 0;
            2:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int unsigned cfg_n(input int k);
        case (k)
            0:       return 4;
            1:       return 5;
            2:       return 2;
            default: return 5;
        endcase
    endfunction

    // ---------------- main instance for directed scenarios ----------------
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [W*N-1:0] req_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;

    mux_pipeline_arbiter #(
        .WIDTH(W), .INPUT_COUNT(N), .LATENCY(L), .TYPE(0), .PRINT(0)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic main_reset();
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_out(input int budget, output int waited);
        waited = 0;
        while (!out_valid && waited < budget) begin
            tick();
            waited++;
        end
        check("wait_out_timeout", 32'(out_valid), 32'd1);
    endtask

    // ---------------- randomized configurations ----------------
    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int unsigned LAT = cfg_lat(g);
        localparam int unsigned NIN = cfg_n(g);
        localparam int unsigned SW  = $clog2(NIN);

        logic             s_rst;
        logic [NIN-1:0]   s_valid;
        logic [NIN-1:0]   s_ready;
        logic [8*NIN-1:0] s_data;
        logic             s_ovalid;
        logic             s_oready;
        logic [7:0]       s_odata;
        logic [SW-1:0]    s_osel;

        mux_pipeline_arbiter #(
            .WIDTH(8), .INPUT_COUNT(NIN), .LATENCY(LAT), .TYPE(0), .PRINT(0)
        ) u_dut (
            .clk       (clk),
            .rst       (s_rst),
            .req_valid (s_valid),
            .req_ready (s_ready),
            .req_data  (s_data),
            .out_valid (s_ovalid),
            .out_ready (s_oready),
            .out_data  (s_odata),
            .out_sel   (s_osel)
        );

        // Model tracks one grant in flight: winner, its data at grant time and
        // the edge on which the result must appear (grant edge + LAT + 1).
        task automatic run(input int cycles);
            int             last, due, gsel, psel;
            logic [7:0]     gdata, pdata;
            bit             busy, pend, arb;
            logic [NIN-1:0] rdy_exp;
            last = NIN - 1;
            busy = 1'b0; pend = 1'b0; rdy_exp = '0;
            gsel = 0; psel = 0; gdata = '0; pdata = '0; due = 0;
            s_rst = 1'b1; s_valid = '0; s_data = '0; s_oready = 1'b0;
            repeat (2) @(negedge clk);
            s_rst = 1'b0;
            check($sformatf("cfg%0d_rst_valid", g), 32'(s_ovalid), 32'd0);
            check($sformatf("cfg%0d_rst_data", g), 32'(s_odata), 32'd0);
            check($sformatf("cfg%0d_rst_ready", g), 32'(s_ready), 32'd0);
            for (int c = 0; c < cycles; c++) begin
                // Requesters change only when idle or just accepted.
                for (int i = 0; i < NIN; i++) begin
                    if (!s_valid[i] || s_ready[i]) begin
                        s_valid[i] = s_ready[i] ? ($urandom_range(0, 1) == 1)
                                                : ($urandom_range(0, 2) == 0);
                        s_data[i*8 +: 8] = 8'($urandom);
                    end
                end
                s_oready = ($urandom_range(0, 3) != 0);
                // Predict the effect of the coming edge (edge number c).
                rdy_exp = '0;
                arb     = 1'b0;
                if (pend) begin
                    if (s_oready) begin
                        pend = 1'b0;
                        arb  = 1'b1;
                    end
                end else if (busy) begin
                    if (c == due) begin
                        pend          = 1'b1;
                        psel          = gsel;
                        pdata         = gdata;
                        rdy_exp[gsel] = 1'b1;
                        busy          = 1'b0;
                    end
                end else begin
                    arb = 1'b1;
                end
                if (arb && (|s_valid)) begin
                    gsel  = rr_model(32'(s_valid), last, NIN);
                    last  = gsel;
                    gdata = s_data[gsel*8 +: 8];
                    busy  = 1'b1;
                    due   = c + LAT + 1;
                end
                @(negedge clk);
                check($sformatf("cfg%0d_out_valid", g), 32'(s_ovalid), 32'(pend));
                if (pend) begin
                    check($sformatf("cfg%0d_out_sel", g), 32'(s_osel), 32'(psel));
                    check($sformatf("cfg%0d_out_data", g), 32'(s_odata), 32'(pdata));
                end
                check($sformatf("cfg%0d_req_ready", g), 32'(s_ready), 32'(rdy_exp));
            end
            s_valid  = '0;
            s_oready = 1'b1;
        endtask
    end

    // ---------------- sequence ----------------
    initial begin
        int w, seen, last_cap, cyc;
        rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;

        // Reset state
        main_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);

        // 1: single request, result in cycle 4, one-cycle req_ready
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        out_ready     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t1_out_valid", 32'(out_valid), 32'(k == 3));
            check("t1_req_ready", 32'(req_ready), (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) begin
                check("t1_out_data", 32'(out_data), 32'hA5);
                check("t1_out_sel", 32'(out_sel), 32'd0);
                req_valid = '0;
            end
        end

        // 2: all requesting, strict rotation every LATENCY+2 cycles
        main_reset();
        for (int i = 0; i < N; i++) req_data[i*8 +: 8] = 8'(16 + i);
        req_valid = 4'hF;
        out_ready = 1'b1;
        seen = 0; last_cap = 0; cyc = 0;
        while (seen < 5 && cyc < 60) begin
            tick();
            cyc++;
            if (out_valid) begin
                check("t2_out_sel", 32'(out_sel), 32'(seen % 4));
                check("t2_out_data", 32'(out_data), 32'(16 + seen % 4));
                check("t2_req_ready", 32'(req_ready), 32'(1 << (seen % 4)));
                if (seen > 0) check("t2_interval", 32'(cyc - last_cap), 32'(L + 2));
                last_cap = cyc;
                seen++;
            end else begin
                check("t2_ready_idle", 32'(req_ready), 32'd0);
            end
        end
        check("t2_results", 32'(seen), 32'd5);
        req_valid = '0;

        // 3: backpressure holds the result; next grant starts on handshake
        main_reset();
        req_valid = 4'b0011;
        out_ready = 1'b0;
        wait_out(20, w);
        check("t3_first_sel", 32'(out_sel), 32'd0);
        check("t3_first_data", 32'(out_data), 32'h10);
        check("t3_first_ready", 32'(req_ready), 32'd1);
        req_valid[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_data", 32'(out_data), 32'h10);
            check("t3_hold_sel", 32'(out_sel), 32'd0);
            check("t3_hold_ready", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("t3_handshake", 32'(out_valid), 32'd0);
        wait_out(20, w);
        check("t3_next_lat", 32'(w), 32'(L + 1));
        check("t3_next_sel", 32'(out_sel), 32'd1);
        check("t3_next_data", 32'(out_data), 32'h11);
        req_valid = '0;

        // 4: requester 2 drops during settle -> abort; requester 3 wins next
        main_reset();
        req_data[2*8 +: 8] = 8'h32;
        req_data[3*8 +: 8] = 8'h43;
        req_data[0*8 +: 8] = 8'h0A;
        req_valid = 4'b0100;
        out_ready = 1'b1;
        tick();
        tick();
        req_valid[2] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t4_abort_valid", 32'(out_valid), 32'd0);
            check("t4_abort_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 4'b1001;
        wait_out(20, w);
        check("t4_latency", 32'(w), 32'(L + 2));
        check("t4_sel", 32'(out_sel), 32'd3);
        check("t4_data", 32'(out_data), 32'h43);
        check("t4_ready", 32'(req_ready), 32'b1000);

        // 5: reset while settling (cnt==1) clears everything
        req_data[1*8 +: 8] = 8'h21;
        req_valid = 4'b0110;
        tick();
        check("t5_held_data", 32'(out_data), 32'h43);
        check("t5_regrant_valid", 32'(out_valid), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_data", 32'(out_data), 32'd0);
        check("t5_rst_sel", 32'(out_sel), 32'd0);
        check("t5_rst_ready", 32'(req_ready), 32'd0);
        req_valid = 4'b0011;
        rst       = 1'b0;
        wait_out(20, w);
        check("t5_first_sel", 32'(out_sel), 32'd0);
        check("t5_first_data", 32'(out_data), 32'h0A);
        check("t5_first_ready", 32'(req_ready), 32'd1);
        req_valid = '0;

        // 6: randomized traffic across configurations
        g_sweep[0].run(600);
        g_sweep[1].run(600);
        g_sweep[2].run(600);
        g_sweep[3].run(600);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
